// File: rtl/calc_engine.sv
// Purpose: four-function signed decimal keypad calculator (add/sub/mul/div) with chaining.
// Latency: add/sub and divide-by-zero take 1 CALC cycle; mul/div take NW CALC cycles; done pulses on RESULT entry.
// Backpressure: key_ready drops during CALC and keys offered then are dropped; no internal queueing.
module calc_engine #(
    parameter int DIGITS = 3,
    parameter int NW     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              key_type,
    output logic              key_ready,
    output logic [2*NW-1:0]   disp_val,
    output logic              disp_neg,
    output logic [1:0]        disp_op,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int RW = 2 * NW;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(NW + 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_CALC    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   a_q, a_d, b_q, b_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]      op_q, op_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [RW-1:0]   acc_q, acc_d;     // product accumulator / division remainder
    logic [RW-1:0]   sh_q, sh_d;       // multiplicand shifted left each mul step
    logic [NW-1:0]   wq_q, wq_d;       // multiplier (shifts right) / dividend-to-quotient (shifts left)
    logic [RW-1:0]   res_q, res_d;
    logic            res_neg_q, res_neg_d;
    logic            done_q, done_d;

    // Key decode: only keys accepted this cycle produce events
    logic            key_acc, dig_k, op_k, eq_k, clr_k, negkey;
    logic [1:0]      key_op;
    logic [NW-1:0]   dig_ext;
    assign key_acc = key_valid && key_ready;
    assign dig_k   = key_acc && !key_type && (key_code <= 4'd9);
    assign op_k    = key_acc && key_type && (key_code >= 4'hA) && (key_code <= 4'hD);
    assign eq_k    = key_acc && key_type && (key_code == 4'hE);
    assign clr_k   = key_acc && key_type && (key_code == 4'hF);
    assign negkey  = key_code == 4'hB;
    assign key_op  = key_code[1:0] ^ 2'b10;   // A->0, B->1, C->2, D->3
    assign dig_ext = {{(NW-4){1'b0}}, key_code};

    // CALC termination conditions
    logic div_zero, calc_last, res_ovf;
    assign div_zero  = (op_q == OP_DIV) && (b_q == '0);
    assign calc_last = (op_q == OP_ADD) || (op_q == OP_SUB) || div_zero ||
                       (iter_q == IW'(NW - 1));
    assign res_ovf   = |res_q[RW-1:NW];

    // Arithmetic step values: signed-magnitude add/sub, one shift-add step, one restoring-divide step
    logic          b_neg_eff, sum_neg, q_bit;
    logic [NW:0]   sum_mag, rem_sh, rem_nx;
    logic [RW-1:0] mul_acc;
    logic [NW-1:0] quo_nx;
    always_comb begin
        b_neg_eff = sb_q ^ (op_q == OP_SUB);
        if (sa_q == b_neg_eff) begin
            sum_mag = {1'b0, a_q} + {1'b0, b_q};
            sum_neg = sa_q;
        end else if (a_q >= b_q) begin
            sum_mag = {1'b0, a_q - b_q};
            sum_neg = sa_q;
        end else begin
            sum_mag = {1'b0, b_q - a_q};
            sum_neg = b_neg_eff;
        end
        if (sum_mag == '0) sum_neg = 1'b0;
        mul_acc = wq_q[0] ? (acc_q + sh_q) : acc_q;
        rem_sh  = {acc_q[NW-1:0], wq_q[NW-1]};
        q_bit   = rem_sh >= {1'b0, b_q};
        rem_nx  = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
        quo_nx  = {wq_q[NW-2:0], q_bit};
    end

    // State register and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ENTER_A;
            a_q       <= '0;
            b_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            op_q      <= OP_ADD;
            iter_q    <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            wq_q      <= '0;
            res_q     <= '0;
            res_neg_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            op_q      <= op_d;
            iter_q    <= iter_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            wq_q      <= wq_d;
            res_q     <= res_d;
            res_neg_q <= res_neg_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A: if (op_k && cnt_a_q != '0) state_d = ST_ENTER_B;
            ST_ENTER_B: if (eq_k && cnt_b_q != '0) state_d = ST_CALC;
            ST_CALC:    if (calc_last) state_d = div_zero ? ST_ERROR : ST_RESULT;
            ST_RESULT: begin
                if (dig_k)     state_d = ST_ENTER_A;
                else if (op_k) state_d = res_ovf ? ST_ERROR : ST_ENTER_B;
            end
            default:    state_d = state_q;
        endcase
        if (clr_k) state_d = ST_ENTER_A;
    end

    // Operand entry, arithmetic iteration and result capture
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        op_d      = op_q;
        iter_d    = iter_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        wq_d      = wq_q;
        res_d     = res_q;
        res_neg_d = res_neg_q;
        done_d    = 1'b0;
        case (state_q)
            ST_ENTER_A: begin
                if (dig_k && cnt_a_q < CW'(DIGITS)) begin
                    a_d     = a_q * NW'(10) + dig_ext;
                    cnt_a_d = cnt_a_q + CW'(1);
                end else if (op_k) begin
                    if (negkey && cnt_a_q == '0) begin
                        sa_d = ~sa_q;
                    end else if (cnt_a_q != '0) begin
                        op_d    = key_op;
                        b_d     = '0;
                        sb_d    = 1'b0;
                        cnt_b_d = '0;
                    end
                end
            end
            ST_ENTER_B: begin
                if (dig_k && cnt_b_q < CW'(DIGITS)) begin
                    b_d     = b_q * NW'(10) + dig_ext;
                    cnt_b_d = cnt_b_q + CW'(1);
                end else if (op_k && cnt_b_q == '0) begin
                    // With no digits yet, B means "negate B"; other operators replace the pending one
                    if (negkey) sb_d = ~sb_q;
                    else        op_d = key_op;
                end else if (eq_k && cnt_b_q != '0) begin
                    iter_d = '0;
                    acc_d  = '0;
                    sh_d   = {{NW{1'b0}}, a_q};
                    wq_d   = (op_q == OP_MUL) ? b_q : a_q;
                end
            end
            ST_CALC: begin
                done_d = calc_last && !div_zero;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_d     = {{(RW-NW-1){1'b0}}, sum_mag};
                        res_neg_d = sum_neg;
                    end
                    OP_MUL: begin
                        acc_d  = mul_acc;
                        sh_d   = {sh_q[RW-2:0], 1'b0};
                        wq_d   = {1'b0, wq_q[NW-1:1]};
                        iter_d = iter_q + IW'(1);
                        if (calc_last) begin
                            res_d     = mul_acc;
                            res_neg_d = (sa_q ^ sb_q) && (mul_acc != '0);
                        end
                    end
                    default: begin
                        if (!div_zero) begin
                            acc_d  = {{(RW-NW-1){1'b0}}, rem_nx};
                            wq_d   = quo_nx;
                            iter_d = iter_q + IW'(1);
                            if (calc_last) begin
                                res_d     = {{NW{1'b0}}, quo_nx};
                                res_neg_d = (sa_q ^ sb_q) && (quo_nx != '0);
                            end
                        end
                    end
                endcase
            end
            ST_RESULT: begin
                if (dig_k) begin
                    a_d     = dig_ext;
                    sa_d    = 1'b0;
                    cnt_a_d = CW'(1);
                    b_d     = '0;
                    sb_d    = 1'b0;
                    cnt_b_d = '0;
                end else if (op_k && !res_ovf) begin
                    // Chaining: the previous result becomes operand A
                    a_d     = res_q[NW-1:0];
                    sa_d    = res_neg_q;
                    cnt_a_d = CW'(1);
                    op_d    = key_op;
                    b_d     = '0;
                    sb_d    = 1'b0;
                    cnt_b_d = '0;
                end
            end
            default: ;
        endcase
        if (clr_k) begin
            a_d     = '0;
            b_d     = '0;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = OP_ADD;
        end
    end

    // Output decode from state
    always_comb begin
        key_ready = state_q != ST_CALC;
        busy      = state_q == ST_CALC;
        err       = state_q == ST_ERROR;
        done      = done_q;
        disp_op   = op_q;
        disp_val  = '0;
        disp_neg  = 1'b0;
        case (state_q)
            ST_ENTER_A: begin
                disp_val = {{NW{1'b0}}, a_q};
                disp_neg = sa_q;
            end
            ST_ENTER_B, ST_CALC: begin
                disp_val = {{NW{1'b0}}, b_q};
                disp_neg = sb_q;
            end
            ST_RESULT: begin
                disp_val = res_q;
                disp_neg = res_neg_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_engine.sv
// Purpose: self-checking bench for calc_engine against a signed-integer calculator model.
// Latency: checks each key one cycle after acceptance; CALC duration counted in cycles.
// Backpressure: keys are only offered outside CALC, except for the deliberate mid-CALC reset.
module tb_calc_engine;
    localparam int DIGITS = 3;
    localparam int NW     = 10;
    localparam int RW     = 2 * NW;
    localparam int S_A = 0, S_B = 1, S_R = 3, S_E = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          key_type = 1'b0;
    logic          key_ready;
    logic [RW-1:0] disp_val;
    logic          disp_neg;
    logic [1:0]    disp_op;
    logic          busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_engine #(.DIGITS(DIGITS), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_type(key_type), .key_ready(key_ready), .disp_val(disp_val),
        .disp_neg(disp_neg), .disp_op(disp_op), .busy(busy), .done(done), .err(err)
    );

    // Reference model: operands as magnitudes with signs, results via plain signed arithmetic
    int     m_st, m_sa, m_sb, m_ca, m_cb, m_op, m_rneg, m_busy;
    longint m_a, m_b, m_res;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_A; m_a = 0; m_b = 0; m_sa = 0; m_sb = 0;
        m_ca = 0; m_cb = 0; m_op = 0; m_res = 0; m_rneg = 0; m_busy = 0;
    endtask

    task automatic model_calc();
        longint va, vb, r;
        va = m_sa ? -m_a : m_a;
        vb = m_sb ? -m_b : m_b;
        case (m_op)
            0: begin r = va + vb; m_busy = 1; end
            1: begin r = va - vb; m_busy = 1; end
            2: begin r = va * vb; m_busy = NW; end
            default: begin
                if (m_b == 0) begin m_busy = 1; m_st = S_E; return; end
                r = va / vb; m_busy = NW;
            end
        endcase
        m_rneg = (r < 0) ? 1 : 0;
        m_res  = (r < 0) ? -r : r;
        m_st   = S_R;
    endtask

    task automatic model_key(input int t, input int c);
        m_busy = 0;
        if (t == 1 && c == 15) begin model_reset(); return; end
        case (m_st)
            S_A, S_B: begin
                if (t == 0 && c <= 9) begin
                    if (m_st == S_A && m_ca < DIGITS) begin m_a = m_a * 10 + c; m_ca++; end
                    if (m_st == S_B && m_cb < DIGITS) begin m_b = m_b * 10 + c; m_cb++; end
                end else if (t == 1 && c >= 10 && c <= 13) begin
                    if (m_st == S_A) begin
                        if (c == 11 && m_ca == 0) m_sa = 1 - m_sa;
                        else if (m_ca > 0) begin
                            m_op = c - 10; m_b = 0; m_sb = 0; m_cb = 0; m_st = S_B;
                        end
                    end else if (m_cb == 0) begin
                        if (c == 11) m_sb = 1 - m_sb;
                        else m_op = c - 10;
                    end
                end else if (t == 1 && c == 14 && m_st == S_B && m_cb > 0) begin
                    model_calc();
                end
            end
            S_R: begin
                if (t == 0 && c <= 9) begin
                    m_a = c; m_sa = 0; m_ca = 1; m_b = 0; m_sb = 0; m_cb = 0; m_st = S_A;
                end else if (t == 1 && c >= 10 && c <= 13) begin
                    if (m_res >= (longint'(1) << NW)) m_st = S_E;
                    else begin
                        m_a = m_res; m_sa = m_rneg; m_ca = 1; m_op = c - 10;
                        m_b = 0; m_sb = 0; m_cb = 0; m_st = S_B;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_disp(input string tag);
        longint ev;
        int     en;
        case (m_st)
            S_A:     begin ev = m_a;   en = m_sa;   end
            S_B:     begin ev = m_b;   en = m_sb;   end
            S_R:     begin ev = m_res; en = m_rneg; end
            default: begin ev = 0;     en = 0;      end
        endcase
        check({tag, ".disp_val"}, longint'(disp_val), ev);
        check({tag, ".disp_neg"}, longint'(disp_neg), en);
        check({tag, ".err"},      longint'(err), (m_st == S_E) ? 1 : 0);
        check({tag, ".disp_op"},  longint'(disp_op), m_op);
        check({tag, ".key_ready"}, longint'(key_ready), 1);
    endtask

    // Offer one key, wait out any CALC phase, then compare against the model
    task automatic press(input int t, input int c);
        int n;
        @(negedge clk);
        key_valid = 1'b1; key_type = t[0]; key_code = c[3:0];
        model_key(t, c);
        @(negedge clk);
        key_valid = 1'b0;
        if (m_busy > 0) begin
            n = 0;
            while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
            check("calc_cycles", n, m_busy);
            check("done_pulse", longint'(done), (m_st == S_R) ? 1 : 0);
        end else begin
            check("no_busy", longint'(busy), 0);
        end
        check_disp("key");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".disp_val"},  longint'(disp_val), 0);
        check({tag, ".disp_neg"},  longint'(disp_neg), 0);
        check({tag, ".disp_op"},   longint'(disp_op), 0);
        check({tag, ".busy"},      longint'(busy), 0);
        check({tag, ".done"},      longint'(done), 0);
        check({tag, ".err"},       longint'(err), 0);
        check({tag, ".key_ready"}, longint'(key_ready), 1);
    endtask

    initial begin
        model_reset();
        // Reset with a coincident key that must be discarded
        rst_n = 1'b0; key_valid = 1'b1; key_type = 1'b0; key_code = 4'd7;
        repeat (2) @(negedge clk);
        key_valid = 1'b0;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_key_dropped", longint'(disp_val), 0);

        // 123 + 45
        press(0, 1); press(0, 2); press(0, 3); press(1, 10); press(0, 4); press(0, 5); press(1, 14);
        check("add_val", longint'(disp_val), 168);
        @(negedge clk);
        check("done_one_cycle", longint'(done), 0);
        press(1, 15);

        // -7 * 9
        press(1, 11); press(0, 7); press(1, 12); press(0, 9); press(1, 14);
        check("mul_val", longint'(disp_val), 63);
        check("mul_neg", longint'(disp_neg), 1);
        press(1, 15);

        // digit limit, divide by zero, error lockout, clear
        press(0, 9); press(0, 9); press(0, 9); press(0, 9);
        check("digit_limit", longint'(disp_val), 999);
        press(1, 13); press(0, 0); press(1, 14);
        check("div0_err", longint'(err), 1);
        press(0, 5);
        check("err_holds", longint'(err), 1);
        press(1, 15);
        check("clear_val", longint'(disp_val), 0);

        // 5 - 5: no negative zero
        press(0, 5); press(1, 11); press(0, 5); press(1, 14);
        check("sub_zero_neg", longint'(disp_neg), 0);
        press(1, 15);

        // 999 * 999 then chaining overflow
        press(0, 9); press(0, 9); press(0, 9); press(1, 12);
        press(0, 9); press(0, 9); press(0, 9); press(1, 14);
        check("big_mul", longint'(disp_val), 998001);
        press(1, 10);
        check("chain_ovf", longint'(err), 1);
        press(1, 15);

        // -100 / 7 then chained + 3 : truncation toward zero and sign carry-over
        press(1, 11); press(0, 1); press(0, 0); press(0, 0); press(1, 13); press(0, 7); press(1, 14);
        check("div_trunc", longint'(disp_val), 14);
        press(1, 10); press(0, 3); press(1, 14);
        check("chain_add", longint'(disp_val), 11);
        check("chain_add_neg", longint'(disp_neg), 1);
        press(1, 15);

        // Reset on the 5th CALC cycle of 8 / 3
        press(0, 8); press(1, 13); press(0, 3);
        @(negedge clk);
        key_valid = 1'b1; key_type = 1'b1; key_code = 4'hE;
        @(negedge clk);
        key_valid = 1'b0;
        check("mid_calc_busy", longint'(busy), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("mid_calc_reset");
        model_reset();
        press(0, 2);
        check("after_reset_digit", longint'(disp_val), 2);
        press(1, 15);

        // Random key stream
        for (int i = 0; i < 400; i++) begin
            int r, t, c;
            r = int'($urandom_range(0, 99));
            if (r < 55)      begin t = 0; c = int'($urandom_range(0, 9)); end
            else if (r < 58) begin t = 0; c = int'($urandom_range(10, 15)); end
            else if (r < 61) begin t = 1; c = int'($urandom_range(0, 9)); end
            else if (r < 80) begin t = 1; c = int'($urandom_range(10, 13)); end
            else if (r < 95) begin t = 1; c = 14; end
            else             begin t = 1; c = 15; end
            press(t, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter DIGITS, default 3: maximum decimal digits per operand.
REQ-002 Parameter NW, default 10: operand magnitude width, SHALL satisfy 2^NW > 10^DIGITS-1.
REQ-003 Derived RW = 2*NW: result magnitude width.
REQ-004 clk  in  1  system clock; every register updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 key_valid  in  1  one-cycle pulse; key_code/key_type are valid this cycle.
REQ-007 key_code  in  4  digit 0-9 when key_type=0; command when key_type=1.
REQ-008 key_type  in  1  0=digit, 1=command.
REQ-009 key_ready  out  1  high when a key is accepted this cycle (state not CALC).
REQ-010 disp_val  out  RW  magnitude currently shown (operand being entered, or result).
REQ-011 disp_neg  out  1  sign of disp_val.
REQ-012 disp_op  out  2  latched operator: 0 add, 1 sub, 2 mul, 3 div.
REQ-013 busy  out  1  high while in CALC.
REQ-014 done  out  1  one-cycle pulse on entry to RESULT.
REQ-015 err  out  1  high while in ERROR.

Function
REQ-016 Command codes: A=add, B=sub, C=mul, D=div, E=equals, F=clear; codes 0-9 with key_type=1 SHALL be ignored.
REQ-017 States: ENTER_A, ENTER_B, CALC, RESULT, ERROR; reset state ENTER_A.
REQ-018 Digit in ENTER_A/ENTER_B: operand <= operand*10 + digit, unless DIGITS digits already entered, in which case the digit is ignored.
REQ-019 B pressed in ENTER_A or ENTER_B with zero digits entered: toggle that operand's sign; no state change.
REQ-020 Operator (A-D) in ENTER_A with at least one digit: latch disp_op, go ENTER_B with B cleared.
REQ-021 Operator in ENTER_B with zero digits: replace disp_op only.
REQ-022 E in ENTER_B with at least one digit: go CALC; E otherwise ignored.
REQ-023 F in any state except CALC: clear A, B, signs, digit counts, disp_op=0; go ENTER_A.
REQ-024 In CALC, key_ready=0 and all keys are dropped, including F.
REQ-025 Add/sub: signed-magnitude, one CALC cycle; result sign SHALL be 0 when magnitude is 0.
REQ-026 Mul: shift-add, exactly NW CALC cycles; sign = sA XOR sB, forced 0 on zero result.
REQ-027 Div: restoring, exactly NW CALC cycles, quotient truncated toward zero, sign = sA XOR sB, forced 0 on zero quotient; remainder discarded.
REQ-028 Div with B=0: go ERROR after one CALC cycle, no iteration.
REQ-029 After CALC, go RESULT with done=1 for that single cycle; disp_val/disp_neg hold result.
REQ-030 Digit in RESULT: start new A containing that digit (ENTER_A).
REQ-031 Operator in RESULT: chaining; A <= result (low NW bits), sign kept, go ENTER_B; if result >= 2^NW, go ERROR instead.
REQ-032 In ERROR, disp_val=0, disp_neg=0; only F is honoured.
REQ-033 disp_val in ENTER_A/ENTER_B shows the operand being entered, zero-extended to RW.

Reset
REQ-034 rst_n low at a clock edge SHALL, in any state including mid-CALC: state=ENTER_A, disp_val=0, disp_neg=0, disp_op=0, busy=0, done=0, err=0, key_ready=1, iteration counter=0, all operand registers 0.
REQ-035 A key_valid coincident with active reset SHALL be discarded.

Verification
REQ-036 Keys 1,2,3,A,4,5,E -> busy 1 cycle, done pulse, disp_val=168, disp_neg=0.
REQ-037 Keys B,7,C,9,E -> busy exactly 10 cycles (NW=10), disp_val=63, disp_neg=1.
REQ-038 Keys 9,9,9,9 -> disp_val=999 (fourth digit ignored); then D,0,E -> err=1; digit 5 -> no change; F -> ENTER_A, disp_val=0.
REQ-039 Keys 5,B,5,E -> disp_val=0, disp_neg=0 (no negative zero).
REQ-040 Keys 9,9,9,C,9,9,9,E then A -> result 998001 shown, then ERROR (chain overflow).
REQ-041 Keys 8,D,3,E with rst_n driven low on the 5th CALC cycle -> all outputs at reset values next cycle; key 2 afterwards -> disp_val=2.
